adc_spi_sampler: RTL and testbench
==================================

Name: adc_spi_sampler

Overview:
- Source end of the receiver DSP sample stream: periodically clocks one conversion out of an external serial (SPI-style, read-only) ADC.
- Presents the unsigned sample with a one-cycle valid strobe, which is the input contract of the DC blocking filter (unsigned data plus valid pulse).
- Sits between the ADC pins and the first DSP stage. Owns conversion timing: sample rate, chip select and serial clock.

Parameters:
- DATA_DW, 12, ADC sample width in bits (unsigned, MSB first on the wire)
- LEAD_BITS, 4, bits clocked before the MSB; discarded
- TRAIL_BITS, 0, bits clocked after the LSB; discarded
- CLK_DIV, 2, clk cycles per sclk phase (low and high each); must be ≥1
- CS_SETUP, 2, clk cycles cs_n_o is low before the first sclk falling edge; must be ≥1
- SAMPLE_PERIOD, 200, clk cycles between conversion triggers; must be ≥2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en_i  in  1  enable periodic conversions
- sdata_i  in  1  ADC serial data; already synchronised externally
- cs_n_o  out  1  ADC chip select, active low
- sclk_o  out  1  ADC serial clock; idles high
- valid_o  out  1  one-cycle strobe; data_o is new
- data_o  out  DATA_DW  last captured sample, unsigned
- busy_o  out  1  high while a frame is in progress (state ≠ IDLE)
- overrun_o  out  1  sticky; a trigger arrived while busy; cleared only by rst

Behaviour:
- Reset (async, all registered outputs):
  - cs_n_o=1, sclk_o=1, valid_o=0, data_o=0, busy_o=0, overrun_o=0.
  - State=IDLE, sample timer=0, shift register=0.
- Frame length N = LEAD_BITS + DATA_DW + TRAIL_BITS.
- Sample timer:
  - While en_i=1: counts 0..SAMPLE_PERIOD-1 and wraps.
  - While en_i=0: forced to 0.
  - trigger = en_i && timer==0, so the first trigger is the first cycle en_i is seen high.
- FSM states: IDLE, SETUP, SHIFT, DONE.
  - IDLE: cs_n_o=1, sclk_o=1. On trigger go to SETUP.
  - SETUP: cs_n_o=0, sclk_o=1 for CS_SETUP cycles, then go to SHIFT.
  - SHIFT: N bit periods of 2*CLK_DIV cycles each; sclk_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - On the clk edge where sclk_o goes 0→1, shift sdata_i into the shift register (MSB first).
    - After the N-th high phase, go to DONE.
  - DONE (exactly 1 cycle):
    - cs_n_o=1, sclk_o=1, valid_o=1.
    - data_o = bits [TRAIL_BITS +: DATA_DW] of the N-bit shift value; lead and trail bits discarded.
    - Then go to IDLE.
- valid_o is 0 in every state other than DONE. data_o holds its value until the next DONE.
- Latency: trigger cycle → valid_o high 1 + CS_SETUP + 2*CLK_DIV*N cycles later. With defaults this is 67 cycles; frame occupancy (busy_o) is 67 cycles.
- Trigger while state≠IDLE:
  - The trigger is dropped and overrun_o is set.
  - The timer keeps running.
  - A trigger arriving in the same cycle DONE→IDLE is also dropped; the FSM is still in DONE that cycle.
- en_i deasserted mid-frame: the current frame completes normally (valid_o still pulses); no further triggers.
- rst mid-frame: immediate return to reset values. No valid_o pulse. cs_n_o returns high asynchronously.
- sclk_o and cs_n_o are driven directly from flops (glitch-free).

Test Plan:
- Defaults, en_i=1, ADC model drives 4 lead ones then 0xA5C → one valid_o pulse 67 cycles after en_i rises; data_o=0xA5C; busy_o high for exactly 67 cycles.
- Defaults, same capture → exactly 16 sclk low pulses per frame, each low 2 and high 2 cycles. cs_n_o falls 2 cycles before the first sclk fall and rises with valid_o.
- Defaults, en_i held high for 1000 cycles with incrementing ADC values → valid_o pulses every 200 cycles (5 pulses), data_o increments each pulse, overrun_o stays 0.
- SAMPLE_PERIOD=50 → triggers at cycles 50, 150, … dropped. Frames start every 100 cycles; overrun_o=1 from cycle 50 onward.
- en_i dropped 20 cycles into a frame → that frame still yields valid_o with correct data; no further cs_n_o activity.
- rst pulsed 30 cycles into a frame → cs_n_o=1, sclk_o=1, data_o=0 and no valid_o. The next frame after rst release captures correctly.

Source files
------------

// File: rtl/adc_spi_sampler_if.sv
// Pin-level bundle between the ADC sampler and its serial ADC / DSP sink.
// master: the sampler; slave: the ADC/sink side.
interface adc_spi_sampler_if #(
  parameter int DATA_DW = 12
);
  logic               en_i;
  logic               sdata_i;
  logic               cs_n_o;
  logic               sclk_o;
  logic               valid_o;
  logic [DATA_DW-1:0] data_o;
  logic               busy_o;
  logic               overrun_o;

  modport master (
    input  en_i, sdata_i,
    output cs_n_o, sclk_o, valid_o,
    output data_o, busy_o, overrun_o
  );

  modport slave (
    output en_i, sdata_i,
    input  cs_n_o, sclk_o, valid_o,
    input  data_o, busy_o, overrun_o
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic read-only serial ADC capture; emits one unsigned sample
// with a single-cycle valid strobe per conversion frame.
module adc_spi_sampler #(
  parameter int DATA_DW       = 12,
  parameter int LEAD_BITS     = 4,
  parameter int TRAIL_BITS    = 0,
  parameter int CLK_DIV       = 2,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic clk,
  input  logic rst,
  adc_spi_sampler_if.master bus
);

  localparam int N    = LEAD_BITS + DATA_DW + TRAIL_BITS;
  localparam int CMAX = (2 * CLK_DIV > CS_SETUP) ?
                        2 * CLK_DIV : CS_SETUP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(N + 1);
  localparam int TW   = $clog2(SAMPLE_PERIOD);

  localparam logic [CW-1:0] SET_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bitn, bit_d;
  logic [TW-1:0] tmr;
  logic [N-1:0]  sr;
  logic          cs_d;
  logic          sclk_d;
  logic          valid_d;
  logic          shift_en;
  logic          trigger;

  assign trigger = bus.en_i && (tmr == '0);

  // Pin levels are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bit_d    = bitn;
    cs_d     = 1'b1;
    sclk_d   = 1'b1;
    valid_d  = 1'b0;
    shift_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_d    = 1'b0;
        end
      end
      SETUP: begin
        cs_d = 1'b0;
        if (cnt == SET_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        cs_d = 1'b0;
        if (cnt == PER_LAST) begin
          cnt_d = '0;
          if (bitn == BIT_LAST) begin
            state_d = DONE;
            cs_d    = 1'b1;
            valid_d = 1'b1;
          end else begin
            bit_d  = bitn + 1'b1;
            sclk_d = 1'b0;
          end
        end else begin
          cnt_d    = cnt + 1'b1;
          sclk_d   = (cnt >= LOW_LAST);
          shift_en = (cnt == LOW_LAST);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bitn          <= '0;
      tmr           <= '0;
      sr            <= '0;
      bus.cs_n_o    <= 1'b1;
      bus.sclk_o    <= 1'b1;
      bus.valid_o   <= 1'b0;
      bus.data_o    <= '0;
      bus.busy_o    <= 1'b0;
      bus.overrun_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bitn        <= bit_d;
      bus.cs_n_o  <= cs_d;
      bus.sclk_o  <= sclk_d;
      bus.valid_o <= valid_d;
      bus.busy_o  <= (state_d != IDLE);
      if (!bus.en_i) begin
        tmr <= '0;
      end else if (tmr == TMR_LAST) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
      if (trigger && (state != IDLE)) begin
        bus.overrun_o <= 1'b1;
      end
      if (shift_en) begin
        sr <= {sr[N-2:0], bus.sdata_i};
      end
      if (valid_d) begin
        bus.data_o <= sr[TRAIL_BITS +: DATA_DW];
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Two samplers (period 200 and 50) against a frame-timing model
// and a behavioural serial ADC.
module tb_adc_spi_sampler;

  localparam int SET = 2;
  localparam int CD  = 2;
  localparam int NB  = 16;
  localparam int LAT = 1 + SET + 2 * CD * NB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en_v = 2'b00;
  logic [1:0]  sd = 2'b00;
  logic [1:0]  cs_v, sc_v, va_v, bu_v, ov_v;
  logic [11:0] dat_v [2];
  logic [11:0] base [2] = '{12'hA5C, 12'h100};

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  int          per [2] = '{200, 50};
  int          rt  [2] = '{0, 0};
  int          fst [2] = '{-100000, -100000};
  int          fcnt[2] = '{0, 0};
  int          bi  [2] = '{0, 0};
  logic        ovr [2] = '{1'b0, 1'b0};
  logic        pcs [2] = '{1'b1, 1'b1};
  logic        psc [2] = '{1'b1, 1'b1};
  logic [11:0] edat[2] = '{12'h0, 12'h0};
  logic [15:0] word[2] = '{16'h0, 16'h0};

  adc_spi_sampler_if #(.DATA_DW(12)) ia ();
  adc_spi_sampler_if #(.DATA_DW(12)) ib ();

  assign ia.en_i    = en_v[0];
  assign ib.en_i    = en_v[1];
  assign ia.sdata_i = sd[0];
  assign ib.sdata_i = sd[1];
  assign cs_v  = {ib.cs_n_o, ia.cs_n_o};
  assign sc_v  = {ib.sclk_o, ia.sclk_o};
  assign va_v  = {ib.valid_o, ia.valid_o};
  assign bu_v  = {ib.busy_o, ia.busy_o};
  assign ov_v  = {ib.overrun_o, ia.overrun_o};
  assign dat_v[0] = ia.data_o;
  assign dat_v[1] = ib.data_o;

  adc_spi_sampler #(.SAMPLE_PERIOD(200)) u0 (
    .clk(clk), .rst(rst), .bus(ia)
  );
  adc_spi_sampler #(.SAMPLE_PERIOD(50)) u1 (
    .clk(clk), .rst(rst), .bus(ib)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int g,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s[%0d] cyc=%0d obs=%0h exp=%0h",
             tag, g, cyc, obs, exp);
    end
  endtask

  // Expected pins follow from the cycle offset into the accepted frame.
  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      int   d;
      logic ebusy, ecs, esc, eval, trig;
      if (rst) begin
        chk("rst_cs", g, cs_v[g], 1);
        chk("rst_sclk", g, sc_v[g], 1);
        chk("rst_valid", g, va_v[g], 0);
        chk("rst_data", g, dat_v[g], 0);
        chk("rst_busy", g, bu_v[g], 0);
        chk("rst_ovr", g, ov_v[g], 0);
        rt[g]   = 0;
        fst[g]  = -100000;
        ovr[g]  = 1'b0;
        edat[g] = 12'h0;
        pcs[g]  = 1'b1;
        psc[g]  = 1'b1;
      end else begin
        d     = cyc - fst[g];
        ebusy = (d >= 1) && (d <= LAT);
        ecs   = !((d >= 1) && (d <= LAT - 1));
        esc   = 1'b1;
        if ((d >= SET + 1) && (d <= LAT - 1))
          esc = ((d - SET - 1) % (2 * CD)) >= CD;
        eval  = (d == LAT);
        if (eval) edat[g] = word[g][11:0];
        chk("cs_n", g, cs_v[g], ecs);
        chk("sclk", g, sc_v[g], esc);
        chk("busy", g, bu_v[g], ebusy);
        chk("valid", g, va_v[g], eval);
        chk("data", g, dat_v[g], edat[g]);
        chk("overrun", g, ov_v[g], ovr[g]);
        trig = 1'b0;
        if (en_v[g]) begin
          trig  = (rt[g] == 0);
          rt[g] = (rt[g] + 1) % per[g];
        end else begin
          rt[g] = 0;
        end
        if (trig) begin
          if (ebusy) ovr[g] = 1'b1;
          else fst[g] = cyc;
        end
        if (pcs[g] && !cs_v[g]) begin
          word[g] = {4'($urandom), 12'(base[g] + fcnt[g])};
          fcnt[g]++;
          bi[g] = 0;
        end
        if (psc[g] && !sc_v[g] && !cs_v[g]) begin
          sd[g] <= word[g][15 - bi[g]];
          bi[g]++;
        end
        pcs[g] = cs_v[g];
        psc[g] = sc_v[g];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    en_v = 2'b11;
    step(1000);
    en_v = 2'b00;
    step(20);
    en_v[0] = 1'b1;
    step(21);
    en_v[0] = 1'b0;
    step(150);
    base[0] = 12'($urandom);
    base[1] = 12'($urandom);
    en_v = 2'b11;
    step(30);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(300);
    for (int k = 0; k < 8; k++) begin
      base[0] = 12'($urandom);
      base[1] = 12'($urandom);
      en_v = 2'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(10, 300));
    end
    en_v = 2'b00;
    step(80);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
